// File: rtl/spi_burst_ctrl.sv
// Byte-burst sequencer feeding an SPI byte engine from a TX FIFO.
// Received bytes are collected into an RX FIFO; slave select is framed with programmable setup/hold.
module spi_burst_fifo #(
  parameter int ADDR_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [7:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0] cnt;
  logic push_ok, pop_ok;

  assign full = (cnt == CNT_FULL);
  assign empty = (cnt == '0);
  assign pop_ok = pop && !empty;
  // A pop frees the slot, so a push on a full FIFO still lands
  assign push_ok = push && (!full || pop_ok);
  assign dout = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= din;
        wptr <= wptr + PTR_ONE;
      end
      if (pop_ok) rptr <= rptr + PTR_ONE;
      if (push_ok && !pop_ok) cnt <= cnt + CNT_ONE;
      else if (!push_ok && pop_ok) cnt <= cnt - CNT_ONE;
    end
  end
endmodule

module spi_burst_ctrl #(
  parameter int ADDR_W = 3,
  parameter int SS_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  input  logic            rd_en,
  output logic [7:0]      rd_data,
  output logic            tx_full,
  output logic            tx_empty,
  output logic            rx_empty,
  output logic            rx_overflow,
  input  logic            clr_ovf,
  input  logic            go,
  input  logic [SS_W-1:0] ss_mask,
  input  logic [15:0]     setup_dly,
  output logic            busy,
  output logic            burst_done,
  output logic [SS_W-1:0] ss_n,
  output logic            spi_start,
  output logic [7:0]      spi_mosi_data,
  input  logic            spi_ready,
  input  logic            spi_done_tick,
  input  logic [7:0]      spi_miso_data
);
  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, HOLD} state_t;

  state_t state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [SS_W-1:0] mask, mask_nx;
  logic rx_push, rx_full, ovf_set;

  spi_burst_fifo #(.ADDR_W(ADDR_W)) u_tx (
    .clk(clk), .reset(reset),
    .push(wr_en), .pop(spi_start),
    .din(wr_data), .dout(spi_mosi_data),
    .full(tx_full), .empty(tx_empty)
  );

  spi_burst_fifo #(.ADDR_W(ADDR_W)) u_rx (
    .clk(clk), .reset(reset),
    .push(rx_push), .pop(rd_en),
    .din(spi_miso_data), .dout(rd_data),
    .full(rx_full), .empty(rx_empty)
  );

  assign busy = (state != IDLE);
  assign ovf_set = rx_push && rx_full && !rd_en;

  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    mask_nx = mask;
    spi_start = 1'b0;
    burst_done = 1'b0;
    rx_push = 1'b0;
    unique case (state)
      IDLE: begin
        if (go && !tx_empty) begin
          mask_nx = ss_mask;
          cnt_nx = '0;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        if (cnt == setup_dly) begin
          cnt_nx = '0;
          state_nx = START;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      START: begin
        if (spi_ready && !tx_empty) begin
          spi_start = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (spi_done_tick) begin
          rx_push = 1'b1;
          // TX cannot pop here, so only a same-cycle write can refill it
          if (!tx_empty || wr_en) begin
            state_nx = START;
          end else begin
            cnt_nx = '0;
            state_nx = HOLD;
          end
        end
      end
      HOLD: begin
        if (cnt == setup_dly) begin
          burst_done = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      mask <= '0;
      ss_n <= '1;
      rx_overflow <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      mask <= mask_nx;
      ss_n <= (state_nx != IDLE) ? ~mask_nx : '1;
      if (ovf_set) rx_overflow <= 1'b1;
      else if (clr_ovf) rx_overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench for spi_burst_ctrl with a simple SPI byte-engine model.
// The engine returns each transmitted byte XORed with 8'h99.
module tb_spi_burst_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic wr_en;
  logic [7:0] wr_data;
  logic rd_en;
  logic [7:0] rd_data;
  logic tx_full, tx_empty, rx_empty, rx_overflow;
  logic clr_ovf;
  logic go;
  logic [3:0] ss_mask;
  logic [15:0] setup_dly;
  logic busy, burst_done;
  logic [3:0] ss_n;
  logic spi_start;
  logic [7:0] spi_mosi_data;
  logic spi_ready;
  logic spi_done_tick;
  logic [7:0] spi_miso_data;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  spi_burst_ctrl #(.ADDR_W(3), .SS_W(4)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data),
    .tx_full(tx_full), .tx_empty(tx_empty),
    .rx_empty(rx_empty), .rx_overflow(rx_overflow),
    .clr_ovf(clr_ovf), .go(go),
    .ss_mask(ss_mask), .setup_dly(setup_dly),
    .busy(busy), .burst_done(burst_done),
    .ss_n(ss_n), .spi_start(spi_start),
    .spi_mosi_data(spi_mosi_data), .spi_ready(spi_ready),
    .spi_done_tick(spi_done_tick), .spi_miso_data(spi_miso_data)
  );

  // Engine model: three busy cycles, then a done tick with the reply
  logic eng_busy;
  logic [1:0] eng_cnt;
  logic [7:0] eng_lat;
  assign spi_ready = !eng_busy;

  always @(posedge clk) begin
    if (reset) begin
      eng_busy <= 1'b0;
      eng_cnt <= 2'd0;
      eng_lat <= 8'h00;
      spi_done_tick <= 1'b0;
      spi_miso_data <= 8'h00;
    end else begin
      spi_done_tick <= 1'b0;
      if (eng_busy) begin
        if (eng_cnt == 2'd0) begin
          eng_busy <= 1'b0;
          spi_done_tick <= 1'b1;
          spi_miso_data <= eng_lat;
        end else begin
          eng_cnt <= eng_cnt - 2'd1;
        end
      end else if (spi_start) begin
        eng_busy <= 1'b1;
        eng_cnt <= 2'd2;
        eng_lat <= spi_mosi_data ^ 8'h99;
      end
    end
  end

  logic [7:0] started [$];
  int done_cnt = 0;
  int ss_gaps = 0;

  always @(negedge clk) begin
    if (spi_start) started.push_back(spi_mosi_data);
    if (burst_done) done_cnt <= done_cnt + 1;
    if (busy && ss_n == 4'hF) ss_gaps <= ss_gaps + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    vecs++;
    assert (obs === req) else begin
      errs++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_data = b;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] req);
    chk(tag, {24'd0, rd_data}, {24'd0, req});
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic go_burst(input logic [3:0] m, input logic [15:0] d);
    ss_mask = m;
    setup_dly = d;
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!burst_done && n < 400) begin
      step();
      n++;
    end
    chk(tag, {31'd0, burst_done}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, g0, n0, n;
    logic [7:0] exp_rx [8];

    reset = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    rd_en = 1'b0;
    clr_ovf = 1'b0;
    go = 1'b0;
    ss_mask = 4'h0;
    setup_dly = 16'd0;
    step();
    step();
    chk("rst_ss_n", ss_n, 4'hF);
    chk("rst_busy", busy, 0);
    chk("rst_start", spi_start, 0);
    chk("rst_done", burst_done, 0);
    chk("rst_ovf", rx_overflow, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_tx_empty", tx_empty, 1);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_mosi", spi_mosi_data, 8'h00);
    reset = 1'b0;
    step();

    // go with TX empty is ignored
    go_burst(4'b0010, 16'd3);
    chk("go_empty_busy", busy, 0);
    chk("go_empty_ss", ss_n, 4'hF);
    step();
    chk("go_empty_busy2", busy, 0);

    // single byte, setup_dly = 3
    d0 = done_cnt;
    push(8'hA5);
    chk("sb_tx_empty", tx_empty, 0);
    chk("sb_mosi_head", spi_mosi_data, 8'hA5);
    go_burst(4'b0010, 16'd3);
    chk("sb_c1_busy", busy, 1);
    chk("sb_c1_ss", ss_n, 4'b1101);
    chk("sb_c1_start", spi_start, 0);
    repeat (3) step();
    chk("sb_c4_start", spi_start, 0);
    chk("sb_c4_ss", ss_n, 4'b1101);
    step();
    chk("sb_c5_start", spi_start, 1);
    chk("sb_c5_mosi", spi_mosi_data, 8'hA5);
    wait_done("sb_done_seen");
    chk("sb_done_ss", ss_n, 4'b1101);
    step();
    chk("sb_end_ss", ss_n, 4'hF);
    chk("sb_end_busy", busy, 0);
    chk("sb_rx_nonempty", rx_empty, 0);
    pop_chk("sb_rx_byte", 8'h3C);
    chk("sb_rx_empty", rx_empty, 1);
    chk("sb_done_count", done_cnt - d0, 1);

    // four-byte burst
    started.delete();
    g0 = ss_gaps;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    go_burst(4'b0101, 16'd1);
    chk("fb_ss", ss_n, 4'b1010);
    wait_done("fb_done_seen");
    step();
    chk("fb_starts", started.size(), 4);
    for (int i = 0; i < 4 && i < started.size(); i++)
      chk("fb_mosi_order", started[i], 8'h01 + 8'(i));
    chk("fb_ss_gaps", ss_gaps - g0, 0);
    pop_chk("fb_rx0", 8'h98);
    pop_chk("fb_rx1", 8'h9B);
    pop_chk("fb_rx2", 8'h9A);
    pop_chk("fb_rx3", 8'h9D);
    chk("fb_rx_empty", rx_empty, 1);

    // TX full push ignored, mid-burst go ignored, RX overflow
    started.delete();
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    chk("ov_tx_full", tx_full, 1);
    push(8'h55);
    chk("ov_tx_full_after_extra", tx_full, 1);
    go_burst(4'b1000, 16'd0);
    chk("ov_ss", ss_n, 4'b0111);
    ss_mask = 4'b0001;
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    chk("ov_midgo_ss", ss_n, 4'b0111);
    chk("ov_midgo_busy", busy, 1);
    n = 0;
    while (tx_full && n < 100) begin
      step();
      n++;
    end
    chk("ov_tx_drained", tx_full, 0);
    push(8'h18);
    wait_done("ov_done_seen");
    step();
    chk("ov_starts", started.size(), 9);
    for (int i = 0; i < 9 && i < started.size(); i++)
      chk("ov_mosi_order", started[i], 8'h10 + 8'(i));
    chk("ov_flag", rx_overflow, 1);
    chk("ov_head", rd_data, 8'h89);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ov_cleared", rx_overflow, 0);

    // pop and push on a full RX in the same cycle
    push(8'h20);
    go_burst(4'b0100, 16'd0);
    n = 0;
    while (!spi_done_tick && n < 100) begin
      step();
      n++;
    end
    chk("pp_done_tick_seen", spi_done_tick, 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("pp_no_ovf", rx_overflow, 0);
    wait_done("pp_done_seen");
    step();
    exp_rx = '{8'h88, 8'h8B, 8'h8A, 8'h8D, 8'h8C, 8'h8F, 8'h8E, 8'hB9};
    for (int i = 0; i < 8; i++) pop_chk("pp_rx_drain", exp_rx[i]);
    chk("pp_rx_empty", rx_empty, 1);

    // reset during WAIT with three bytes queued
    started.delete();
    push(8'h31);
    push(8'h32);
    push(8'h33);
    push(8'h34);
    go_burst(4'b0011, 16'd1);
    n = 0;
    while (!spi_start && n < 100) begin
      step();
      n++;
    end
    chk("mr_start_seen", spi_start, 1);
    step();
    chk("mr_busy_before", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_ss", ss_n, 4'hF);
    chk("mr_busy", busy, 0);
    chk("mr_tx_empty", tx_empty, 1);
    chk("mr_rx_empty", rx_empty, 1);
    n0 = started.size();
    repeat (30) step();
    chk("mr_no_start", started.size(), n0);
    chk("mr_rx_still_empty", rx_empty, 1);

    // zero delay
    push(8'h5A);
    go_burst(4'b1001, 16'd0);
    chk("zd_c1_start", spi_start, 0);
    chk("zd_c1_ss", ss_n, 4'b0110);
    step();
    chk("zd_c2_start", spi_start, 1);
    chk("zd_c2_mosi", spi_mosi_data, 8'h5A);
    wait_done("zd_done_seen");
    chk("zd_done_ss", ss_n, 4'b0110);
    step();
    chk("zd_end_ss", ss_n, 4'hF);
    chk("zd_end_busy", busy, 0);
    pop_chk("zd_rx", 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/spi_burst_ctrl.md
# spi_burst_ctrl

Byte-burst sequencer placed directly upstream of the SPI byte engine in the SPI MMIO core. The processor pushes bytes into a TX FIFO and issues `go`. The block then asserts the selected slave-select lines and feeds the engine one byte at a time through its `start`/`ready`/`done_tick` handshake. Each received byte is collected into an RX FIFO, and slave select is released after a programmable hold time.

## Interface
- `ADDR_W`, default 3: FIFO address width; each FIFO holds 2^ADDR_W bytes.
- `SS_W`, default 4: number of slave-select lines.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `wr_en`  in  1  push `wr_data` into the TX FIFO.
- `wr_data`  in  8  TX byte.
- `rd_en`  in  1  pop the RX FIFO head.
- `rd_data`  out  8  RX FIFO head (first-word fall-through).
- `tx_full`  out  1  TX FIFO full.
- `tx_empty`  out  1  TX FIFO empty.
- `rx_empty`  out  1  RX FIFO empty.
- `rx_overflow`  out  1  sticky; a received byte was dropped because the RX FIFO was full.
- `clr_ovf`  in  1  clear `rx_overflow`.
- `go`  in  1  start a burst.
- `ss_mask`  in  SS_W  lines to assert for the burst; 1 = select.
- `setup_dly`  in  16  ss-to-first-clock and last-byte-to-ss-release delay, in cycles minus one.
- `busy`  out  1  burst in progress.
- `burst_done`  out  1  one-cycle pulse at burst end.
- `ss_n`  out  SS_W  active-low slave selects, registered.
- `spi_start`  out  1  to engine `start`.
- `spi_mosi_data`  out  8  to engine `mosi_data`; equals the TX FIFO head.
- `spi_ready`  in  1  from engine `ready`.
- `spi_done_tick`  in  1  from engine `done_tick`.
- `spi_miso_data`  in  8  from engine `miso_data`.

## Operation
The FSM has five states: IDLE, SETUP, START, WAIT and HOLD.

- **IDLE**
  - `go`=1 with `tx_empty`=0 latches `ss_mask`, clears the delay counter and moves to SETUP.
  - `go` with TX empty is ignored. `go` in any other state is ignored.
- **SETUP**
  - The counter increments each cycle.
  - When count == `setup_dly`, clear the counter and go to START.
- **START**
  - When `spi_ready`=1: assert `spi_start` (combinational, this cycle only), pop TX, go to WAIT.
  - Otherwise stay in START.
- **WAIT**
  - On `spi_done_tick`, push `spi_miso_data` into the RX FIFO.
  - Then go to START if TX is non-empty after this cycle's activity. Otherwise clear the counter and go to HOLD.
- **HOLD**
  - When count == `setup_dly`, go to IDLE and pulse `burst_done`.

Outputs by state:
- `ss_n` = ~latched mask whenever the next state is not IDLE; otherwise all ones. It is registered, so it changes one cycle after the state decision.
- `busy` = (state != IDLE).

FIFO rules:
- Storage is circular with ADDR_W-bit pointers plus a count or extra bit. Pointers wrap modulo 2^ADDR_W.
- Push when full is ignored. Pop when empty is ignored.
- Simultaneous push and pop on a full FIFO: both take effect and the count is unchanged.
- Simultaneous push and pop on an empty FIFO: the pop is ignored and the push takes effect.
- `wr_en` during a burst is allowed. Bytes pushed before WAIT evaluates TX emptiness extend the burst.
- RX push while RX is full (and no same-cycle `rd_en`): the byte is dropped and `rx_overflow` is set.
- `clr_ovf` and a new overflow in the same cycle: `rx_overflow` stays set.

Reset (any state, including mid-burst):
- State returns to IDLE, both FIFOs are emptied, and the counter clears.
- Output values after reset:
  - `ss_n` = all ones.
  - `busy`, `spi_start`, `burst_done`, `rx_overflow`, `tx_full` = 0.
  - `tx_empty`, `rx_empty` = 1.
  - `rd_data` = 8'h00 and `spi_mosi_data` = 8'h00, because storage clears to 0.
- The engine shares `reset`, so there is no partial-byte recovery.

## Timing
- Let cycle 0 be the edge that samples `go`. Then `busy`=1 and `ss_n` is low from cycle 1.
- SETUP lasts `setup_dly`+1 cycles. `spi_start` therefore fires `setup_dly`+2 cycles after `go`, provided `spi_ready` is high.
- Byte-to-byte: the `spi_done_tick` cycle is followed by START one cycle later, and `spi_start` is asserted as soon as the engine reports `spi_ready`.
- HOLD lasts `setup_dly`+1 cycles. `burst_done` is high in the final HOLD cycle.
- `ss_n` returns high and `busy` drops on the following cycle.
- `setup_dly`=0 gives a single-cycle SETUP and a single-cycle HOLD.
- TX pop, RX push and the flag updates all take effect one cycle after the triggering edge.
- `rd_data` updates in the cycle after a pop or after a push into an empty FIFO.

## Test plan
- **Single byte.**
  - Stimulus: reset, push 8'hA5, `ss_mask`=4'b0010, `setup_dly`=3, `go`; engine model returns 8'h3C.
  - Required: `ss_n`=4'b1101 from cycle 1; `spi_start` at cycle 5 with `spi_mosi_data`=8'hA5; RX holds 8'h3C; `burst_done` pulses once; then `ss_n`=4'hF.
- **Four-byte burst.**
  - Stimulus: push 01, 02, 03, 04, then `go`.
  - Required: four `spi_start` pulses in order; `ss_n` stays low continuously between bytes; RX pops the four echoed bytes in order.
- **Overflow.**
  - Stimulus: depth 8, push 9 bytes, `go`, never read.
  - Required: RX holds the first 8 bytes and `rx_overflow`=1.
  - Then `clr_ovf` clears it, and one `rd_en` in the same cycle as a push on a full RX loses nothing.
- **Ignored requests.**
  - Stimulus: `go` with TX empty; `go` mid-burst; TX push when full.
  - Required: no state change from the ignored `go`s; TX count stays 8 after the extra push.
- **Reset mid-burst.**
  - Stimulus: assert `reset` during WAIT with 3 bytes still queued.
  - Required: the next cycle shows `ss_n`=4'hF, `busy`=0, `tx_empty`=1, `rx_empty`=1, and no further `spi_start`.
- **Zero delay.**
  - Stimulus: `setup_dly`=0, one byte, `go`.
  - Required: `spi_start` at cycle 2, and `ss_n` high one cycle after `burst_done`.
